// File: rtl/mult_rr_scheduler.sv
// Round-robin front end sharing one iterative 32x32 multiplier between NREQ requesters.
// Optional watchdog on the multiplier wait: define MULT_TIMEOUT_EN.
module mult_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [32*NREQ-1:0]   req_a_i,
  input  logic [32*NREQ-1:0]   req_b_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic                 resp_valid_o,
  output logic [IDW-1:0]       resp_id_o,
  output logic [63:0]          resp_r_o,
  output logic                 resp_err_o,
  output logic                 busy_o,
  output logic                 mult_valid_in_o,
  output logic [31:0]          mult_a_o,
  output logic [31:0]          mult_b_o,
  input  logic                 mult_valid_out_i,
  input  logic [63:0]          mult_r_i
);

  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT < 1) begin : g_param_check
    $error("mult_rr_scheduler: inconsistent NREQ/IDW/TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_q;
  logic [IDW-1:0] rr_q;
  logic [IDW-1:0] tag_q;
  logic [31:0]    mult_a_q;
  logic [31:0]    mult_b_q;
  logic           mult_valid_in_q;
  logic           resp_valid_q;
  logic [IDW-1:0] resp_id_q;
  logic [63:0]    resp_r_q;

  logic [IDW-1:0] scan;
  logic [IDW-1:0] winner;
  logic           found;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;

`ifdef MULT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_q;
  logic          resp_err_q;
  assign resp_err_o = resp_err_q;
`else
  assign resp_err_o = 1'b0;
`endif

  // Scan starts one past the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = rr_q;
    for (int i = 0; i < NREQ; i++) begin
      scan = (scan == IDW'(NREQ - 1)) ? '0 : scan + IDW'(1);
      if (!found && req_valid_i[scan]) begin
        found  = 1'b1;
        winner = scan;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (winner == IDW'(k)) begin
        sel_a = req_a_i[32*k +: 32];
        sel_b = req_b_i[32*k +: 32];
      end
    end
  end

  assign req_ready_o     = (state_q == IDLE && found && !rst_i) ? (NREQ'(1) << winner) : '0;
  assign busy_o          = (state_q != IDLE);
  assign mult_valid_in_o = mult_valid_in_q;
  assign mult_a_o        = mult_a_q;
  assign mult_b_o        = mult_b_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_id_o       = resp_id_q;
  assign resp_r_o        = resp_r_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      rr_q            <= IDW'(NREQ - 1);
      tag_q           <= '0;
      mult_a_q        <= '0;
      mult_b_q        <= '0;
      mult_valid_in_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= '0;
      resp_r_q        <= '0;
`ifdef MULT_TIMEOUT_EN
      wait_cnt_q      <= '0;
      resp_err_q      <= 1'b0;
`endif
    end else begin
      mult_valid_in_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            mult_a_q        <= sel_a;
            mult_b_q        <= sel_b;
            tag_q           <= winner;
            rr_q            <= winner;
            mult_valid_in_q <= 1'b1;
            state_q         <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef MULT_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        WAIT: begin
          if (mult_valid_out_i) begin
            resp_r_q     <= mult_r_i;
            resp_id_q    <= tag_q;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
`ifdef MULT_TIMEOUT_EN
            resp_err_q   <= 1'b0;
          end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            // Multiplier never answered: return an error response so the requester is not stranded.
            resp_r_q     <= '0;
            resp_id_q    <= tag_q;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            state_q      <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
`endif
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler: table-driven single jobs, a scoreboard on the
// response port, and hand-written sequences for latency, fairness, reset abort and timeout.
module tb_mult_rr_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TOUT = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     req_ready;
  logic                resp_valid;
  logic [IDW-1:0]      resp_id;
  logic [63:0]         resp_r;
  logic                resp_err;
  logic                busy;
  logic                mult_valid_in;
  logic [31:0]         mult_a;
  logic [31:0]         mult_b;
  logic                mult_valid_out;
  logic [63:0]         mult_r;

  typedef struct {
    logic [IDW-1:0] id;
    logic [63:0]    r;
    logic           err;
  } exp_t;

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
  } vec_t;

  exp_t expQ[$];
  vec_t vecs[5];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   respCount = 0;
  int   modelLat  = 3;
  bit   modelNever = 1'b0;

  mult_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TOUT)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_a_i          (req_a),
    .req_b_i          (req_b),
    .req_ready_o      (req_ready),
    .resp_valid_o     (resp_valid),
    .resp_id_o        (resp_id),
    .resp_r_o         (resp_r),
    .resp_err_o       (resp_err),
    .busy_o           (busy),
    .mult_valid_in_o  (mult_valid_in),
    .mult_a_o         (mult_a),
    .mult_b_o         (mult_b),
    .mult_valid_out_i (mult_valid_out),
    .mult_r_i         (mult_r)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Multiplier model: answers modelLat cycles after the start pulse with the product.
  initial begin
    int remain;
    logic [63:0] pa;
    logic [63:0] pb;
    logic sv;
    remain = 0;
    pa = '0;
    pb = '0;
    mult_valid_out = 1'b0;
    mult_r = '0;
    forever begin
      @(posedge clk);
      sv = mult_valid_in;
      if (sv) begin
        pa = {32'd0, mult_a};
        pb = {32'd0, mult_b};
      end
      #1;
      mult_valid_out = 1'b0;
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          mult_valid_out = 1'b1;
          mult_r = pa * pb;
        end
      end
      if (sv && !modelNever) begin
        if (modelLat <= 1) begin
          mult_valid_out = 1'b1;
          mult_r = pa * pb;
        end else begin
          remain = modelLat - 1;
        end
      end
    end
  end

  // Scoreboard: every response must match the oldest outstanding expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (resp_valid) begin
      respCount++;
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_resp: got id=%0d r=%0h err=%0b, required no response", resp_id, resp_r, resp_err);
      end else begin
        e = expQ.pop_front();
        if (resp_id !== e.id || resp_r !== e.r || resp_err !== e.err) begin
          failures++;
          $display("[TB] FAIL resp: got id=%0d r=%0h err=%0b, required id=%0d r=%0h err=%0b",
                   resp_id, resp_r, resp_err, e.id, e.r, e.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] b);
    req_a[32*k +: 32] = a;
    req_b[32*k +: 32] = b;
  endtask

  task automatic waitGrant(output logic [NREQ-1:0] g);
    g = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = req_ready;
        break;
      end
      tick();
    end
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (expQ.size() == 0) break;
      tick();
    end
    checkOutput({name, "_drain"}, 64'(expQ.size()), 64'd0);
    tick();
  endtask

  task automatic runSingle(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] r, input string name);
    logic [NREQ-1:0] g;
    applyStimulus(k, a, b);
    req_valid = NREQ'(1) << k;
    expQ.push_back('{IDW'(k), r, 1'b0});
    waitGrant(g);
    checkOutput({name, "_grant"}, 64'(g), 64'(NREQ'(1) << k));
    tick();
    req_valid = '0;
    waitDrain(name);
  endtask

  initial begin
    logic [NREQ-1:0] g;
    int prevCyc;
    int t0;
    int rc;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;

    vecs[0] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[1] = '{2, 32'd0,        32'd12345,    64'd0};
    vecs[2] = '{3, 32'd3,        32'd5,        64'd15};
    vecs[3] = '{0, 32'h12345678, 32'h10,       64'h123456780};
    vecs[4] = '{1, 32'd100000,   32'd100000,   64'd10000000000};

    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_busy",     64'(busy), 64'd0);
    checkOutput("rst_ready",    64'(req_ready), 64'd0);
    checkOutput("rst_mvi",      64'(mult_valid_in), 64'd0);
    checkOutput("rst_resp_v",   64'(resp_valid), 64'd0);
    checkOutput("rst_resp_err", 64'(resp_err), 64'd0);
    checkOutput("rst_mult_a",   64'(mult_a), 64'd0);
    checkOutput("rst_resp_r",   resp_r, 64'd0);
    tick();
    rst = 1'b0;

    // Cycle-exact latency: accept T, start pulse T+1, result T+4, response T+5.
    modelLat = 3;
    applyStimulus(0, 32'd6, 32'd7);
    req_valid = 4'b0001;
    expQ.push_back('{2'd0, 64'd42, 1'b0});
    @(negedge clk);
    checkOutput("lat_ready_T", 64'(req_ready), 64'b0001);
    checkOutput("lat_mvi_T",   64'(mult_valid_in), 64'd0);
    tick();
    req_valid = '0;
    @(negedge clk);
    checkOutput("lat_mvi_T1",   64'(mult_valid_in), 64'd1);
    checkOutput("lat_ready_T1", 64'(req_ready), 64'd0);
    checkOutput("lat_busy_T1",  64'(busy), 64'd1);
    checkOutput("lat_mult_a",   64'(mult_a), 64'd6);
    checkOutput("lat_mult_b",   64'(mult_b), 64'd7);
    tick();
    @(negedge clk);
    checkOutput("lat_mvi_T2", 64'(mult_valid_in), 64'd0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("lat_rv_T4", 64'(resp_valid), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("lat_rv_T5", 64'(resp_valid), 64'd1);
    tick();
    @(negedge clk);
    checkOutput("lat_rv_T6",   64'(resp_valid), 64'd0);
    checkOutput("lat_busy_T6", 64'(busy), 64'd0);
    checkOutput("lat_hold_r",  resp_r, 64'd42);
    tick();

    for (int i = 0; i < 5; i++) begin
      modelLat = 1 + (i % 4);
      runSingle(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].r, $sformatf("vec%0d", i));
    end

    // Fairness with all requesters busy, fastest multiplier: 4-cycle turnaround.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelLat = 1;
    for (int k = 0; k < NREQ; k++) applyStimulus(k, 32'(k + 1), 32'd10);
    req_valid = 4'b1111;
    prevCyc = 0;
    for (int i = 0; i < 5; i++) begin
      waitGrant(g);
      checkOutput($sformatf("rr_grant%0d", i), 64'(g), 64'(NREQ'(1) << (i % NREQ)));
      expQ.push_back('{IDW'(i % NREQ), 64'((i % NREQ + 1) * 10), 1'b0});
      if (i > 0) checkOutput($sformatf("rr_turn%0d", i), 64'(cyc - prevCyc), 64'd4);
      prevCyc = cyc;
      tick();
    end
    req_valid = '0;
    waitDrain("rr");

    // Pointer at 1: requester 3 precedes 0; a request dropped before grant is forgotten.
    modelLat = 2;
    runSingle(1, 32'd2, 32'd2, 64'd4, "ptr1");
    applyStimulus(0, 32'd7, 32'd8);
    applyStimulus(3, 32'd9, 32'd9);
    req_valid = 4'b1001;
    waitGrant(g);
    checkOutput("ptr_first", 64'(g), 64'b1000);
    expQ.push_back('{2'd3, 64'd81, 1'b0});
    tick();
    req_valid = 4'b0101;
    waitGrant(g);
    checkOutput("ptr_second", 64'(g), 64'b0001);
    expQ.push_back('{2'd0, 64'd56, 1'b0});
    tick();
    req_valid = '0;
    waitDrain("ptr");
    tick();
    @(negedge clk);
    checkOutput("drop_busy", 64'(busy), 64'd0);
    tick();

    // Reset while waiting on the multiplier; its late answer must be ignored.
    modelLat = 6;
    applyStimulus(1, 32'd11, 32'd13);
    req_valid = 4'b0010;
    waitGrant(g);
    checkOutput("abort_grant", 64'(g), 64'b0010);
    tick();
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy",   64'(busy), 64'd0);
    checkOutput("abort_resp_r", resp_r, 64'd0);
    checkOutput("abort_mult_a", 64'(mult_a), 64'd0);
    rc = respCount;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("abort_no_resp", 64'(respCount - rc), 64'd0);
    modelLat = 3;
    runSingle(2, 32'd3, 32'd5, 64'd15, "after_abort");

`ifdef MULT_TIMEOUT_EN
    modelNever = 1'b1;
    applyStimulus(1, 32'd5, 32'd5);
    req_valid = 4'b0010;
    expQ.push_back('{2'd1, 64'd0, 1'b1});
    waitGrant(g);
    checkOutput("to_grant", 64'(g), 64'b0010);
    t0 = cyc;
    tick();
    req_valid = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) break;
      tick();
    end
    checkOutput("to_latency", 64'(cyc - t0), 64'd10);
    tick();
    modelNever = 1'b0;
    waitDrain("to");
    runSingle(2, 32'd4, 32'd4, 64'd16, "after_to");
`else
    t0 = 0;
`endif

    checkOutput("final_queue", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Shares one iterative 32x32 multiplier (valid_in / a / b -> valid_out / r, variable latency) between NREQ requesters.
- Round-robin arbitration, one operation in flight at a time, operand capture, tagged result return.
- Sits between the requester blocks and the single multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester tag; must equal clog2(NREQ), minimum 1.
- TIMEOUT, 64, watchdog limit in cycles (used only with MULT_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_a  in  32*NREQ  operand a; requester k in bits [32k+31:32k].
- req_b  in  32*NREQ  operand b; same packing.
- req_ready  out  NREQ  one-hot; request accepted this cycle.
- resp_valid  out  1  result valid; single-cycle pulse, no backpressure.
- resp_id  out  IDW  requester index owning resp_r.
- resp_r  out  64  product.
- resp_err  out  1  timeout flag; tied 0 without the macro.
- busy  out  1  high in any state other than IDLE.
- mult_valid_in  out  1  start pulse to the multiplier.
- mult_a  out  32  registered operand a.
- mult_b  out  32  registered operand b.
- mult_valid_out  in  1  multiplier done.
- mult_r  in  64  multiplier result.

Behaviour:
- Reset:
  - State = IDLE, rr_ptr = NREQ-1, so requester 0 wins first.
  - req_ready = 0, resp_valid = 0, resp_err = 0, mult_valid_in = 0.
  - mult_a = 0, mult_b = 0, resp_r = 0, resp_id = 0.
  - Reset mid-operation abandons the job; no response is issued. A late mult_valid_out after reset is ignored because the FSM is in IDLE.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE (arbitration):
  - Search req_valid starting at rr_ptr+1, wrapping modulo NREQ; the first set bit wins.
  - The winner's req_ready is asserted combinationally in this cycle; this is the only cycle the request is accepted.
  - On the clock edge: capture the winner's a/b into mult_a/mult_b, store the tag, set rr_ptr = winner, go to ISSUE.
  - No req_valid set: stay in IDLE.
  - req_ready is 0 in every state other than IDLE.
- ISSUE:
  - mult_valid_in = 1 for exactly this cycle.
  - mult_a/mult_b are held stable until the job completes.
  - Go to WAIT.
- WAIT:
  - Stay until mult_valid_out = 1.
  - On that edge: capture mult_r into resp_r, go to RESP.
  - mult_valid_out is ignored in all other states.
- RESP:
  - resp_valid = 1, resp_id = stored tag, for one cycle; go to IDLE.
  - resp_r and resp_id hold their values until the next response.
- Latency:
  - Accept at cycle T; mult_valid_in at T+1.
  - If mult_valid_out arrives at cycle W, resp_valid is at W+1.
  - Minimum turnaround is 4 cycles from one accept to the next.
- Fairness: a continuously requesting requester waits at most NREQ-1 other jobs.
- Simultaneous events:
  - A requester may deassert req_valid before it is granted; this is legal and the request is not remembered.
  - A new request arriving during RESP waits until IDLE.

Optional Feature:
- Macro: MULT_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no mult_valid_out, go to RESP with resp_r = 0 and resp_err = 1.
  - resp_err is 0 for normal responses.
- Without the macro:
  - No counter; WAIT is unbounded; resp_err is constant 0.

Test Plan:
- After reset, req_valid=0001, a=6, b=7, model multiplier answers 3 cycles after its start pulse -> req_ready=0001 at T, mult_valid_in at T+1, resp_valid with resp_id=0 and resp_r=42 at T+5.
- All four requesters hold req_valid=1111 with a=k+1, b=10 -> grant order 0,1,2,3,0; resp_r = 10, 20, 30, 40, 10.
- rr_ptr=1, req_valid=1001 -> requester 3 granted before 0; next grant goes to 0.
- a=FFFFFFFF, b=FFFFFFFF -> resp_r=FFFFFFFE00000001; a=0, b=12345 -> resp_r=0.
- rst asserted for 1 cycle during WAIT, then the stale mult_valid_out arrives -> no resp_valid; the next request (id 2, 3x5) returns 15 with resp_id=2.
- With MULT_TIMEOUT_EN and TIMEOUT=8, model multiplier never responds -> resp_valid, resp_err=1, resp_r=0 at 8 WAIT cycles + 1; the FSM returns to IDLE and accepts the next request.
